// File: rtl/leaf_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter_if
// Bundles the user-side request/accept signals, the destination config write
// port, the downstream credit return, the resend control and the outgoing
// BFT packet of leaf_out_arbiter.
//   din_leaf_user2interface  user words, port i at slice i
//   vld_user2interface       per-port word valid
//   ack_interface2user       per-port accept (combinational in the arbiter)
//   cfg_wr/cfg_port/cfg_leaf/cfg_dport  destination config write
//   cred_vld/cred_port/cred_amt         credit return from downstream
//   resend                   suspends issue while high
//   dout_leaf_interface2bft  registered outgoing packet
// modport slave  : the arbiter side
// modport master : the user / test side
// ---------------------------------------------------------------------------
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 4
) ();
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic                                  cfg_wr;
  logic [NUM_PORT_BITS-1:0]              cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dport;
  logic                                  cred_vld;
  logic [NUM_PORT_BITS-1:0]              cred_port;
  logic [NUM_ADDR_BITS:0]                cred_amt;
  logic                                  resend;
  logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

  modport slave (
    input  din_leaf_user2interface, vld_user2interface,
    input  cfg_wr, cfg_port, cfg_leaf, cfg_dport,
    input  cred_vld, cred_port, cred_amt, resend,
    output ack_interface2user, dout_leaf_interface2bft
  );

  modport master (
    output din_leaf_user2interface, vld_user2interface,
    output cfg_wr, cfg_port, cfg_leaf, cfg_dport,
    output cred_vld, cred_port, cred_amt, resend,
    input  ack_interface2user, dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter
// Round-robin arbiter that turns per-port user words into BFT packets.
// Each port carries a destination (leaf, port), a sequence counter and a
// credit counter. A port is granted when it has valid data, a valid config,
// non-zero credit and resend is low. The granted word is wrapped into
//   [48] valid | [47:43] leaf | [42:39] port | [38:32] seq | [31:0] payload
// and presented on the registered output one cycle after the grant.
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   bus    leaf_out_arbiter_if.slave (user side, config, credits, packet out)
// ---------------------------------------------------------------------------
module leaf_out_arbiter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 4,
  parameter int CREDIT_INIT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  leaf_out_arbiter_if.slave  bus
);

  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam int PTR_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int SEQ_LSB   = PAYLOAD_BITS;
  localparam int DPORT_LSB = SEQ_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB  = DPORT_LSB + NUM_PORT_BITS;
  // One extra bit so credit + return cannot wrap before saturation.
  localparam logic [CRED_BITS:0] CREDIT_MAX = (CRED_BITS+1)'(2**NUM_ADDR_BITS);

  logic [NUM_OUT_PORTS-1:0]                    eligible;
  logic [NUM_OUT_PORTS-1:0]                    grant_onehot;
  logic [NUM_OUT_PORTS-1:0][NUM_LEAF_BITS-1:0] port_leaf;
  logic [NUM_OUT_PORTS-1:0][NUM_PORT_BITS-1:0] port_dport;
  logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] port_seq;

  logic                   any_grant;
  logic                   grant_valid;
  logic [PTR_BITS-1:0]    grant_idx;
  logic [PTR_BITS-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [PACKET_BITS-1:0] dout_reg, dout_next;
  int                     search_idx;

  // -------------------------------------------------------------------------
  // Per-port state: destination config, sequence counter, credit counter.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : gen_port
      logic                     cfg_valid_reg;
      logic [NUM_LEAF_BITS-1:0] leaf_reg;
      logic [NUM_PORT_BITS-1:0] dport_reg;
      logic [NUM_ADDR_BITS-1:0] seq_reg;
      logic [CRED_BITS-1:0]     credit_reg, credit_next;
      logic [CRED_BITS:0]       credit_sum;
      logic                     cfg_hit, cred_hit;

      // Out-of-range port numbers never match any gi, so they are dropped.
      assign cfg_hit  = bus.cfg_wr   && (bus.cfg_port  == NUM_PORT_BITS'(gi));
      assign cred_hit = bus.cred_vld && (bus.cred_port == NUM_PORT_BITS'(gi));

      assign eligible[gi] = bus.vld_user2interface[gi] && cfg_valid_reg &&
                            (credit_reg != '0) && !bus.resend;

      assign port_leaf[gi]  = leaf_reg;
      assign port_dport[gi] = dport_reg;
      assign port_seq[gi]   = seq_reg;

      // Return and grant are combined first, then clamped to the ceiling.
      always_comb begin
        credit_sum = {1'b0, credit_reg};
        if (cred_hit)
          credit_sum = credit_sum + {1'b0, bus.cred_amt};
        if (grant_onehot[gi])
          credit_sum = credit_sum - (CRED_BITS+1)'(1);
        if (credit_sum > CREDIT_MAX)
          credit_next = CREDIT_MAX[CRED_BITS-1:0];
        else
          credit_next = credit_sum[CRED_BITS-1:0];
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          cfg_valid_reg <= 1'b0;
          leaf_reg      <= '0;
          dport_reg     <= '0;
          seq_reg       <= '0;
          credit_reg    <= CRED_BITS'(CREDIT_INIT);
        end else begin
          if (cfg_hit) begin
            cfg_valid_reg <= 1'b1;
            leaf_reg      <= bus.cfg_leaf;
            dport_reg     <= bus.cfg_dport;
          end
          if (grant_onehot[gi])
            seq_reg <= seq_reg + NUM_ADDR_BITS'(1);
          credit_reg <= credit_next;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr, ascending with wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    any_grant  = 1'b0;
    grant_idx  = '0;
    search_idx = 0;
    for (int off = 0; off < NUM_OUT_PORTS; off++) begin
      search_idx = int'(rr_ptr_reg) + off;
      if (search_idx >= NUM_OUT_PORTS)
        search_idx = search_idx - NUM_OUT_PORTS;
      if (!any_grant && eligible[search_idx]) begin
        any_grant = 1'b1;
        grant_idx = PTR_BITS'(search_idx);
      end
    end
  end

  // Holding reset low suppresses acks even though eligibility is unaffected.
  assign grant_valid = any_grant && reset;

  always_comb begin
    grant_onehot = '0;
    if (grant_valid)
      grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      if (int'(grant_idx) == NUM_OUT_PORTS - 1)
        rr_ptr_next = '0;
      else
        rr_ptr_next = grant_idx + PTR_BITS'(1);
    end
  end

  // Packet is assembled from the registered header state of the granted port.
  always_comb begin
    dout_next = '0;
    if (grant_valid) begin
      dout_next[PAYLOAD_BITS-1:0] =
        bus.din_leaf_user2interface[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
      dout_next[SEQ_LSB   +: NUM_ADDR_BITS] = port_seq[grant_idx];
      dout_next[DPORT_LSB +: NUM_PORT_BITS] = port_dport[grant_idx];
      dout_next[LEAF_LSB  +: NUM_LEAF_BITS] = port_leaf[grant_idx];
      dout_next[PACKET_BITS-1]              = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_reg   <= '0;
      rr_ptr_reg <= '0;
    end else begin
      dout_reg   <= dout_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign bus.ack_interface2user      = grant_onehot;
  assign bus.dout_leaf_interface2bft = dout_reg;

endmodule
